// File: rtl/toggle_period_meter_if.sv
// Signal bundle between a toggle source/consumer and toggle_period_meter.
// The master side drives enable and the toggle input, and the slave side returns the measurement.
interface toggle_period_meter_if #(
    parameter int BITLEN = 8
);
    logic              en;
    logic              hz_in;
    logic [BITLEN-1:0] lim_out;
    logic              valid;
    logic              locked;
    logic              overflow;

    modport master (
        output en,
        output hz_in,
        input  lim_out,
        input  valid,
        input  locked,
        input  overflow
    );

    modport slave (
        input  en,
        input  hz_in,
        output lim_out,
        output valid,
        output locked,
        output overflow
    );
endinterface

// File: rtl/toggle_period_meter.sv
// Measures the half-period of a (possibly asynchronous) square wave and
// reports the divider limit that produced it, plus lock and overflow status.
module toggle_period_meter #(
    parameter int BITLEN      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    toggle_period_meter_if.slave  bus
);
    localparam int CW = BITLEN + 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX  = {1'b1, {BITLEN{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEEK = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hs_s;
    logic                   hs_d_r;
    logic                   edge_s;

    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_nxt_s;
    logic [CW-1:0]     cnt_m1_s;
    logic [BITLEN-1:0] meas_lim_s;
    logic [BITLEN-1:0] lim_r;
    logic [BITLEN-1:0] lim_nxt_s;
    logic              valid_r;
    logic              valid_nxt_s;
    logic              locked_r;
    logic              locked_nxt_s;
    logic              overflow_r;
    logic              overflow_nxt_s;
    logic              have_prev_r;
    logic              have_prev_nxt_s;

    assign hs_s       = sync_r[SYNC_STAGES-1];
    assign edge_s     = hs_s ^ hs_d_r;
    // cnt is at least 1 on every edge seen in MEAS, so this never wraps.
    assign cnt_m1_s   = cnt_r - CNT_ONE;
    assign meas_lim_s = cnt_m1_s[BITLEN-1:0];

    // Synchroniser chain and delayed copy for both-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            hs_d_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.hz_in};
            hs_d_r <= hs_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; dropping en wins over everything, including a same-cycle edge.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.en) begin
                    state_nxt_s = ST_SEEK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEEK: begin
                if (!bus.en) begin
                    state_nxt_s = ST_IDLE;
                end else if (edge_s) begin
                    state_nxt_s = ST_MEAS;
                end else begin
                    state_nxt_s = ST_SEEK;
                end
            end
            ST_MEAS: begin
                if (!bus.en) begin
                    state_nxt_s = ST_IDLE;
                end else if (edge_s) begin
                    state_nxt_s = ST_MEAS;
                end else if (cnt_r == CNT_MAX) begin
                    state_nxt_s = ST_SEEK;
                end else begin
                    state_nxt_s = ST_MEAS;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and status next values, all registered below.
    always_comb begin
        cnt_nxt_s       = cnt_r;
        lim_nxt_s       = lim_r;
        valid_nxt_s     = 1'b0;
        locked_nxt_s    = locked_r;
        overflow_nxt_s  = overflow_r;
        have_prev_nxt_s = have_prev_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s       = CNT_ZERO;
                locked_nxt_s    = 1'b0;
                have_prev_nxt_s = 1'b0;
            end
            ST_SEEK: begin
                if (!bus.en) begin
                    cnt_nxt_s       = CNT_ZERO;
                    locked_nxt_s    = 1'b0;
                    have_prev_nxt_s = 1'b0;
                end else if (edge_s) begin
                    cnt_nxt_s = CNT_ONE;
                end else begin
                    cnt_nxt_s = CNT_ZERO;
                end
            end
            ST_MEAS: begin
                if (!bus.en) begin
                    cnt_nxt_s       = CNT_ZERO;
                    locked_nxt_s    = 1'b0;
                    have_prev_nxt_s = 1'b0;
                end else if (edge_s) begin
                    lim_nxt_s       = meas_lim_s;
                    valid_nxt_s     = 1'b1;
                    cnt_nxt_s       = CNT_ONE;
                    overflow_nxt_s  = 1'b0;
                    locked_nxt_s    = (meas_lim_s == lim_r) && have_prev_r;
                    have_prev_nxt_s = 1'b1;
                end else if (cnt_r == CNT_MAX) begin
                    cnt_nxt_s       = CNT_ZERO;
                    overflow_nxt_s  = 1'b1;
                    locked_nxt_s    = 1'b0;
                    have_prev_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                cnt_nxt_s       = CNT_ZERO;
                locked_nxt_s    = 1'b0;
                have_prev_nxt_s = 1'b0;
            end
        endcase
    end

    // Counter, measurement and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= CNT_ZERO;
            lim_r       <= {BITLEN{1'b0}};
            valid_r     <= 1'b0;
            locked_r    <= 1'b0;
            overflow_r  <= 1'b0;
            have_prev_r <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            lim_r       <= lim_nxt_s;
            valid_r     <= valid_nxt_s;
            locked_r    <= locked_nxt_s;
            overflow_r  <= overflow_nxt_s;
            have_prev_r <= have_prev_nxt_s;
        end
    end

    assign bus.lim_out  = lim_r;
    assign bus.valid    = valid_r;
    assign bus.locked   = locked_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_toggle_period_meter.sv
// Scoreboard bench for toggle_period_meter: each driven toggle pushes the
// measurement it should produce, and every valid pulse pops and compares.
module tb_toggle_period_meter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    toggle_period_meter_if #(.BITLEN(8)) tpm_if ();

    toggle_period_meter #(.BITLEN(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tpm_if)
    );

    typedef struct {
        logic [7:0] lim;
        logic       locked;
    } exp_t;

    exp_t sb_q[$];
    int   err_cnt  = 0;
    int   chk_cnt  = 0;
    int   cyc      = 0;
    int   last_cyc = 0;
    bit   armed     = 1'b0;
    bit   have_prev = 1'b0;
    logic [7:0] last_lim = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Expected outcome of a toggle that arrives iv clk cycles after the previous one.
    task automatic model_edge(input int iv);
        exp_t e;
        if (!armed) begin
            armed = 1'b1;
        end else if (iv - 1 > 255) begin
            have_prev = 1'b0;
        end else begin
            e.lim    = 8'(iv - 1);
            e.locked = have_prev && (e.lim == last_lim);
            sb_q.push_back(e);
            last_lim  = e.lim;
            have_prev = 1'b1;
        end
    endtask

    task automatic toggle();
        @(negedge clk);
        tpm_if.hz_in = ~tpm_if.hz_in;
        model_edge(cyc - last_cyc);
        last_cyc = cyc;
    endtask

    task automatic toggle_after(input int h);
        repeat (h - 1) @(negedge clk);
        toggle();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart_model();
        armed     = 1'b0;
        have_prev = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && tpm_if.valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("lim_out", 32'(tpm_if.lim_out), 32'(e.lim));
                check("locked", 32'(tpm_if.locked), 32'(e.locked));
                check("overflow_clr", 32'(tpm_if.overflow), 32'd0);
            end
        end
    end

    initial begin
        tpm_if.hz_in = 1'b0;
        tpm_if.en    = 1'b0;
        wait_cyc(3);
        check("rst_lim", 32'(tpm_if.lim_out), 32'd0);
        check("rst_valid", 32'(tpm_if.valid), 32'd0);
        check("rst_locked", 32'(tpm_if.locked), 32'd0);
        check("rst_overflow", 32'(tpm_if.overflow), 32'd0);
        rst_n = 1'b1;
        tpm_if.en = 1'b1;
        restart_model();
        wait_cyc(5);

        // Divider limit 5, then a switch to 9 mid-stream.
        for (int i = 0; i < 5; i++) toggle_after(6);
        wait_cyc(6);
        check("t1_locked", 32'(tpm_if.locked), 32'd1);
        for (int i = 0; i < 4; i++) toggle_after(10);
        wait_cyc(6);

        // Minimum period: toggle every clk cycle.
        for (int i = 0; i < 8; i++) toggle_after(1);
        wait_cyc(6);

        // Largest measurable limit, then a hold long enough to overflow.
        for (int i = 0; i < 3; i++) toggle_after(256);
        wait_cyc(300);
        check("ovf_set", 32'(tpm_if.overflow), 32'd1);
        check("ovf_locked", 32'(tpm_if.locked), 32'd0);
        check("ovf_sb_empty", 32'(sb_q.size()), 32'd0);
        toggle();
        for (int i = 0; i < 3; i++) toggle_after(6);
        wait_cyc(6);

        // en drops in the very cycle the synchronised edge is consumed.
        wait_cyc(5);
        tpm_if.hz_in = ~tpm_if.hz_in;
        last_cyc = cyc;
        wait_cyc(2);
        tpm_if.en = 1'b0;
        restart_model();
        wait_cyc(8);
        check("en_drop_locked", 32'(tpm_if.locked), 32'd0);
        check("en_drop_sb_empty", 32'(sb_q.size()), 32'd0);
        tpm_if.en = 1'b1;
        wait_cyc(4);
        for (int i = 0; i < 3; i++) toggle_after(7);
        wait_cyc(6);

        // Asynchronous reset in the middle of a measurement.
        if (tpm_if.hz_in) begin
            toggle_after(7);
            wait_cyc(6);
        end
        wait_cyc(5);
        check("pre_rst_sb_empty", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_lim", 32'(tpm_if.lim_out), 32'd0);
        check("mid_rst_valid", 32'(tpm_if.valid), 32'd0);
        check("mid_rst_locked", 32'(tpm_if.locked), 32'd0);
        check("mid_rst_overflow", 32'(tpm_if.overflow), 32'd0);
        restart_model();
        last_lim = 8'd0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(4);
        for (int i = 0; i < 3; i++) toggle_after(8);
        wait_cyc(8);

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
